// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
//
// Handshake: in_data is consumed on a rising clock edge where in_valid=1 and
// in_ready=1. The source may raise or drop in_valid freely; while in_ready=0
// nothing is consumed. The source holds in_data steady while in_valid=1 and the
// byte has not been taken. mem_we is a single-cycle write strobe qualified by
// mem_addr/mem_wdata. There is no back-pressure on the memory side.
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    // Host side: supplies the byte stream and observes the memory writes.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes the byte stream and drives the memory writes.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a length byte, that many program bytes and a
// checksum byte. It writes the program bytes to instruction memory from
// address 0, then releases the CPU core from reset if the checksum matches.
// A zero length, a checksum mismatch or too long a silence on the stream all
// end in the error state. The CPU stays in reset in every state except RUN.
module prog_loader #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    prog_loader_if.slave bus,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [7:0]  loaded_len,
    output logic [2:0]  state_dbg
);

    // State encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // The silence counter trips on the edge where it would reach TIMEOUT,
    // so the compare is against TIMEOUT-1 on the pre-increment value.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [7:0]  byte_cnt;
    logic [7:0]  sum;
    logic [15:0] tmo_cnt;

    logic        loading;
    logic        xfer;
    logic        tmo_hit;
    logic [7:0]  cnt_inc;
    logic [7:0]  sum_next;

    // Handshake qualifiers and datapath helpers
    always_comb begin
        loading  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
        xfer     = loading && bus.in_valid;
        // A transfer on the would-be timeout edge wins over the timeout.
        tmo_hit  = loading && !bus.in_valid && (tmo_cnt == TMO_LAST);
        cnt_inc  = byte_cnt + 8'd1;
        sum_next = sum + bus.in_data;
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    state_next = (bus.in_data == 8'd0) ? S_ERR : S_DATA;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // cnt_inc cannot wrap: byte_cnt stays below loaded_len.
                    if (cnt_inc == loaded_len) begin
                        state_next = S_CSUM;
                    end
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_next = (bus.in_data == sum) ? S_RUN : S_ERR;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Silence counter: runs while loading, cleared by any transfer or exit
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 16'd0;
        end else if (loading && !xfer && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    // Length header latch
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_len <= 8'd0;
        end else if (state == S_LEN && xfer && bus.in_data != 8'd0) begin
            loaded_len <= bus.in_data;
        end
    end

    // Byte counter and running checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 8'd0;
            sum      <= 8'd0;
        end else if ((state == S_IDLE || state == S_RUN || state == S_ERR) && start) begin
            byte_cnt <= 8'd0;
            sum      <= 8'd0;
        end else if (state == S_LEN && xfer) begin
            byte_cnt <= 8'd0;
            sum      <= 8'd0;
        end else if (state == S_DATA && xfer) begin
            byte_cnt <= cnt_inc;
            sum      <= sum_next;
        end
    end

    // Instruction memory write: one-cycle strobe after each program byte
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 8'd0;
            bus.mem_wdata <= 8'd0;
        end else if (state == S_DATA && xfer) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= byte_cnt;
            bus.mem_wdata <= bus.in_data;
        end else begin
            bus.mem_we    <= 1'b0;
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        bus.in_ready = loading;
        done         = (state == S_RUN);
        error        = (state == S_ERR);
        cpu_reset    = (state != S_RUN);
        state_dbg    = state;
    end

endmodule
